// File: rtl/prio_load_reg_pkg.sv
// Shared types and default constants for the priority load register.
package prio_load_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    VALID  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 2;
  localparam int DEF_NCH     = 3;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_RST_VAL = 0;

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: lowest asserted request index wins.
module prio_enc #(
  parameter int NCH   = 3,
  parameter int IDX_W = 2
) (
  input  logic [NCH-1:0]   i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_hit
);

  always_comb begin
    o_idx = '0;
    o_hit = |i_req;
    // Scan downwards so the lowest set bit is the last (winning) assignment.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/prio_load_reg.sv
// Register written from prioritised load channels or default data, with a lock mode.
// Change counter is built only when PRIO_LOAD_REG_CNT_EN is defined; otherwise chg_cnt reads 0.
module prio_load_reg
  import prio_load_reg_pkg::*;
#(
  parameter int                WIDTH   = DEF_WIDTH,
  parameter int                NCH     = DEF_NCH,
  parameter logic [WIDTH-1:0]  RST_VAL = WIDTH'(DEF_RST_VAL),
  parameter int                CNT_W   = DEF_CNT_W,
  localparam int               IDX_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   r,
  input  logic [NCH-1:0]         ld,
  input  logic [NCH*WIDTH-1:0]   ld_val,
  input  logic                   en,
  input  logic [WIDTH-1:0]       d,
  input  logic                   lock,
  output logic [WIDTH-1:0]       q,
  output logic                   q_vld,
  output logic [IDX_W-1:0]       win,
  output logic                   win_vld,
  output logic [CNT_W-1:0]       chg_cnt,
  output state_t                 o_dbg_state
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [IDX_W-1:0] r_win;
  logic             r_win_vld;

  logic             w_locked;
  logic [NCH-1:0]   w_req;
  logic [IDX_W-1:0] w_idx;
  logic             w_hit;
  logic             w_d_wr;
  logic             w_wr;
  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] w_q_nxt;

  // Lock only masks inputs while it is still asserted; dropping it restores normal rules on that edge.
  assign w_locked = (r_state == LOCKED) && lock;
  assign w_req    = w_locked ? (ld & NCH'(1)) : ld;
  assign w_d_wr   = !w_hit && en && !w_locked;
  assign w_wr     = w_hit || w_d_wr;

  prio_enc #(
    .NCH   (NCH),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .i_req (w_req),
    .o_idx (w_idx),
    .o_hit (w_hit)
  );

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_idx == IDX_W'(i)) w_sel = ld_val[i*WIDTH +: WIDTH];
    end
  end

  assign w_q_nxt = w_hit ? w_sel : (w_d_wr ? d : r_q);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_wr) w_state_nxt = VALID;
      VALID:   if (lock) w_state_nxt = LOCKED;
      LOCKED:  if (!lock) w_state_nxt = VALID;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_state   <= EMPTY;
      r_q       <= RST_VAL;
      r_win     <= '0;
      r_win_vld <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      if (w_wr) begin
        r_win_vld <= w_hit;
        if (w_hit) r_win <= w_idx;
      end
    end
  end

`ifdef PRIO_LOAD_REG_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturating count of edges where q actually took a different value.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_cnt <= '0;
    end else if ((w_q_nxt != r_q) && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign chg_cnt = r_cnt;
`else
  assign chg_cnt = '0;
`endif

  assign q           = r_q;
  assign q_vld       = (r_state != EMPTY);
  assign win         = r_win;
  assign win_vld     = r_win_vld;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_prio_load_reg.sv
// Directed bench for prio_load_reg: queued expectations checked by a per-cycle monitor.
module tb_prio_load_reg;
  import prio_load_reg_pkg::*;

  logic       clk = 1'b0;
  logic       r   = 1'b1;
  logic [2:0] ld  = '0;
  logic [5:0] ld_val = '0;
  logic       en  = 1'b0;
  logic [1:0] d   = '0;
  logic       lock = 1'b0;
  logic [1:0] q;
  logic       q_vld;
  logic [1:0] win;
  logic       win_vld;
  logic [7:0] chg_cnt;
  state_t     st;

  logic       en2 = 1'b0;
  logic [1:0] d2  = '0;
  logic [1:0] q2;
  logic       q_vld2;
  logic [1:0] win2;
  logic       win_vld2;
  logic [1:0] chg_cnt2;
  state_t     st2;

  logic [15:0] exp_q[$];
  string       tag_q[$];
  logic [1:0]  exp2_q[$];
  string       tag2_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  prio_load_reg dut (
    .clk(clk), .r(r), .ld(ld), .ld_val(ld_val), .en(en), .d(d), .lock(lock),
    .q(q), .q_vld(q_vld), .win(win), .win_vld(win_vld), .chg_cnt(chg_cnt),
    .o_dbg_state(st)
  );

  prio_load_reg #(.CNT_W(2)) dut_sat (
    .clk(clk), .r(r), .ld(3'b000), .ld_val(6'b0), .en(en2), .d(d2), .lock(1'b0),
    .q(q2), .q_vld(q_vld2), .win(win2), .win_vld(win_vld2), .chg_cnt(chg_cnt2),
    .o_dbg_state(st2)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- helpers ----
  function automatic logic [7:0] cexp(input int n);
`ifdef PRIO_LOAD_REG_CNT_EN
    return 8'(n);
`else
    return 8'(n * 0);
`endif
  endfunction

  // {state, q, q_vld, win, win_vld, chg_cnt}
  function automatic logic [15:0] ex(input int s, input int qq, input int qv,
                                     input int w, input int wv, input int c);
    return {2'(s), 2'(qq), 1'(qv), 2'(w), 1'(wv), cexp(c)};
  endfunction

  function automatic logic [15:0] act();
    return {st, q, q_vld, win, win_vld, chg_cnt};
  endfunction

  task automatic chk(input string name, input logic [15:0] a, input logic [15:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got st=%0d q=%0d q_vld=%0d win=%0d win_vld=%0d cnt=%0d, want st=%0d q=%0d q_vld=%0d win=%0d win_vld=%0d cnt=%0d",
                  name, a[15:14], a[13:12], a[11], a[10:9], a[8], a[7:0],
                  e[15:14], e[13:12], e[11], e[10:9], e[8], e[7:0]);
  endtask

  // ---- drivers ----
  task automatic step(input string name, input logic [2:0] l, input logic [5:0] lv,
                      input logic e, input logic [1:0] dd, input logic lk,
                      input logic [15:0] expv);
    @(negedge clk);
    ld = l; ld_val = lv; en = e; d = dd; lock = lk;
    exp_q.push_back(expv);
    tag_q.push_back(name);
    @(posedge clk);
  endtask

  task automatic step_sat(input string name, input logic [1:0] dd, input int c);
    @(negedge clk);
    en2 = 1'b1; d2 = dd;
    exp2_q.push_back(cexp(c)[1:0]);
    tag2_q.push_back(name);
    @(posedge clk);
  endtask

  // ---- scoreboard monitor ----
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) chk(tag_q.pop_front(), act(), exp_q.pop_front());
    if (exp2_q.size() > 0) begin
      logic [1:0] e2;
      string      t2;
      e2 = exp2_q.pop_front();
      t2 = tag2_q.pop_front();
      n_chk++;
      if (chg_cnt2 === e2) n_pass++;
      else $display("FAIL %s: chg_cnt got %0d want %0d", t2, chg_cnt2, e2);
    end
  end

  // ---- stimulus ----
  initial begin
    #2;
    chk("reset_state", act(), ex(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    r = 1'b0;

    step("lock_in_empty", 3'b000, 6'b00_00_00, 1'b0, 2'd0, 1'b1, ex(0, 0, 0, 0, 0, 0));
    step("ld_ch1_wins",   3'b110, 6'b10_01_00, 1'b0, 2'd0, 1'b0, ex(1, 1, 1, 1, 1, 1));
    step("d_write",       3'b000, 6'b00_00_00, 1'b1, 2'd3, 1'b0, ex(1, 3, 1, 1, 0, 2));
    step("d_same_value",  3'b000, 6'b00_00_00, 1'b1, 2'd3, 1'b0, ex(1, 3, 1, 1, 0, 2));
    step("hold",          3'b000, 6'b00_00_00, 1'b0, 2'd1, 1'b0, ex(1, 3, 1, 1, 0, 2));
    step("ld_ch2",        3'b100, 6'b00_11_11, 1'b1, 2'd1, 1'b0, ex(1, 0, 1, 2, 1, 3));
    step("lock_same_wr",  3'b000, 6'b00_00_00, 1'b1, 2'd2, 1'b1, ex(2, 2, 1, 2, 0, 4));
    step("locked_ignore", 3'b100, 6'b10_00_00, 1'b1, 2'd0, 1'b1, ex(2, 2, 1, 2, 0, 4));
    step("locked_ch0",    3'b001, 6'b00_00_01, 1'b1, 2'd0, 1'b1, ex(2, 1, 1, 0, 1, 5));
    step("locked_ch0_01", 3'b011, 6'b00_10_11, 1'b0, 2'd0, 1'b1, ex(2, 3, 1, 0, 1, 6));
    step("unlock_d",      3'b000, 6'b00_00_00, 1'b1, 2'd0, 1'b0, ex(1, 0, 1, 0, 0, 7));
    step("relock_d",      3'b000, 6'b00_00_00, 1'b1, 2'd3, 1'b1, ex(2, 3, 1, 0, 0, 8));

    // Asynchronous reset between edges while LOCKED, then held across an edge with a load.
    #3;
    r = 1'b1;
    #1;
    chk("async_reset", act(), ex(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    ld = 3'b001; ld_val = 6'b00_00_01; en = 1'b1; d = 2'd2; lock = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_priority", act(), ex(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    r = 1'b0;
    ld = '0; en = 1'b0; lock = 1'b0;

    step("after_reset_d", 3'b000, 6'b00_00_00, 1'b1, 2'd1, 1'b0, ex(1, 1, 1, 0, 0, 1));

    // Saturating counter on the CNT_W=2 instance; main instance idles.
    @(negedge clk);
    ld = '0; en = 1'b0; lock = 1'b0;
    step_sat("sat_w1", 2'd1, 1);
    step_sat("sat_w2", 2'd2, 2);
    step_sat("sat_w3", 2'd1, 3);
    step_sat("sat_w4", 2'd2, 3);
    step_sat("sat_w5", 2'd1, 3);
    @(negedge clk);
    en2 = 1'b0;
    @(negedge clk);
    chk("main_idle_hold", act(), ex(1, 1, 1, 0, 0, 1));
    n_chk++;
    if (exp_q.size() == 0 && exp2_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d/%0d expectations left, want 0/0", exp_q.size(), exp2_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
